// File: rtl/regfile_pkg.sv
// Shared constants and write-request type for the register file write path.
// Imported by the write-port arbiter and its bench.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO buffering auxiliary-unit writes to the register file.
// Ports: push/pop with addr/data, head entry, full/empty flags, and a
// per-entry valid+addr view used for hazard comparison.
module regfile_wr_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [ADDR_W-1:0]              push_addr,
   input  logic [DATA_W-1:0]              push_data,
   output logic [ADDR_W-1:0]              head_addr,
   output logic [DATA_W-1:0]              head_data,
   output logic                           full,
   output logic                           empty,
   output logic [DEPTH-1:0]               ent_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;

   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

   logic do_push;
   logic do_pop;
   logic [PTR_W-1:0] off;

   assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];
   assign ent_addr  = addr_q;

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         addr_d[wr_ptr_q] = push_addr;
         data_d[wr_ptr_q] = push_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      ent_valid = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off          = PTR_W'(i) - rd_ptr_q;
         ent_valid[i] = ({1'b0, off} < cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between writeback (priority) and a
// buffered auxiliary unit, with starvation stall and hazard check outputs.
module regfile_wr_arbiter #(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_stall,
   input  logic              aux_valid,
   output logic              aux_ready,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_data,
   output logic              regwrite,
   output logic [ADDR_W-1:0] writereg,
   output logic [DATA_W-1:0] writedata,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              chk_hit1,
   output logic              chk_hit2
);

   import regfile_pkg::*;

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic                  full, empty, push, pop, take_wb;
   logic [ADDR_W-1:0]     head_addr;
   logic [DATA_W-1:0]     head_data;
   logic [FIFO_DEPTH-1:0] ent_valid;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;

   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              stall_q, stall_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] writereg_q, writereg_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic              buf_hit1, buf_hit2;

   regfile_wr_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_addr (aux_addr),
      .push_data (aux_data),
      .head_addr (head_addr),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
   );

   assign aux_ready = !full;
   assign push      = aux_valid && !full;
   // Forced drain wins over writeback; otherwise drain only when wb is idle.
   assign pop       = !empty && (stall_q || !wb_valid);
   assign take_wb   = wb_valid && !(stall_q && !empty);
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign wb_stall  = stall_q;

   always_comb begin
      cnt_d       = '0;
      stall_d     = 1'b0;
      regwrite_d  = 1'b0;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      if (take_wb) begin
         regwrite_d  = (wb_addr != ZERO);
         writereg_d  = wb_addr;
         writedata_d = wb_data;
         if (!empty) begin
            cnt_d   = cnt_inc;
            stall_d = (cnt_inc == CNT_W'(STARVE_MAX));
         end
      end else if (pop) begin
         regwrite_d  = (head_addr != ZERO);
         writereg_d  = head_addr;
         writedata_d = head_data;
      end
   end

   always_comb begin
      buf_hit1 = 1'b0;
      buf_hit2 = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_valid[i] && ent_addr[i] == chk_addr1) buf_hit1 = 1'b1;
         if (ent_valid[i] && ent_addr[i] == chk_addr2) buf_hit2 = 1'b1;
      end
      chk_hit1 = (chk_addr1 != ZERO) &&
                 (buf_hit1 || (regwrite_q && writereg_q == chk_addr1));
      chk_hit2 = (chk_addr2 != ZERO) &&
                 (buf_hit2 || (regwrite_q && writereg_q == chk_addr2));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         stall_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
      end
   end

   assign regwrite  = regwrite_q;
   assign writereg  = writereg_q;
   assign writedata = writedata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, starvation stall, FIFO
// fill/order, register zero, hazard check and mid-operation reset.
module tb_regfile_wr_arbiter;

   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_stall;
   logic              aux_valid;
   logic              aux_ready;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_data;
   logic              regwrite;
   logic [ADDR_W-1:0] writereg;
   logic [DATA_W-1:0] writedata;
   logic [ADDR_W-1:0] chk_addr1;
   logic [ADDR_W-1:0] chk_addr2;
   logic              chk_hit1;
   logic              chk_hit2;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_wr_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (4),
      .STARVE_MAX (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .wb_stall  (wb_stall),
      .aux_valid (aux_valid),
      .aux_ready (aux_ready),
      .aux_addr  (aux_addr),
      .aux_data  (aux_data),
      .regwrite  (regwrite),
      .writereg  (writereg),
      .writedata (writedata),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .chk_hit1  (chk_hit1),
      .chk_hit2  (chk_hit2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   wr_req_t exp_q[8];
   int      wbi;
   int      stalls;

   initial begin
      reset     = 1'b1;
      wb_valid  = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      aux_valid = 1'b1;
      aux_addr  = 5'd9;
      aux_data  = 32'h11;
      chk_addr1 = 5'd9;
      chk_addr2 = 5'd0;

      // Reset state with aux_valid held high
      @(negedge clk);
      check("rst_aux_ready", aux_ready, 1);
      check("rst_regwrite", regwrite, 0);
      check("rst_writereg", writereg, 0);
      check("rst_writedata", writedata, 0);
      check("rst_wb_stall", wb_stall, 0);
      check("rst_hit1", chk_hit1, 0);
      @(negedge clk);
      check("rst_no_push", chk_hit1, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("aux_lat0_rw", regwrite, 0);
      tick();
      aux_valid = 1'b0;
      @(negedge clk);
      check("aux_lat1_rw", regwrite, 0);
      check("aux_lat1_hit", chk_hit1, 1);
      tick();
      @(negedge clk);
      check("aux_lat2_rw", regwrite, 1);
      check("aux_lat2_reg", writereg, 9);
      check("aux_lat2_data", writedata, 32'h11);
      check("aux_lat2_hit", chk_hit1, 1);
      tick();
      @(negedge clk);
      check("idle_rw", regwrite, 0);
      check("idle_hold_reg", writereg, 9);
      check("idle_hold_data", writedata, 32'h11);
      check("idle_hit", chk_hit1, 0);

      // Starvation: continuous writeback, one aux entry
      exp_q[1] = '{addr: 5'd8,  data: 32'd0};
      exp_q[2] = '{addr: 5'd8,  data: 32'd1};
      exp_q[3] = '{addr: 5'd8,  data: 32'd2};
      exp_q[4] = '{addr: 5'd8,  data: 32'd3};
      exp_q[5] = '{addr: 5'd10, data: 32'hAA};
      exp_q[6] = '{addr: 5'd8,  data: 32'd4};
      exp_q[7] = '{addr: 5'd8,  data: 32'd5};
      wbi    = 0;
      stalls = 0;
      tick();
      for (int k = 0; k < 8; k++) begin
         wb_valid  = 1'b1;
         wb_addr   = 5'd8;
         wb_data   = DATA_W'(wbi);
         aux_valid = (k == 0);
         aux_addr  = 5'd10;
         aux_data  = 32'hAA;
         @(negedge clk);
         check($sformatf("starve_stall%0d", k), wb_stall, 64'(k == 4));
         if (wb_stall) stalls++;
         if (k >= 1) begin
            check($sformatf("starve_rw%0d", k), regwrite, 1);
            check($sformatf("starve_reg%0d", k), writereg, exp_q[k].addr);
            check($sformatf("starve_data%0d", k), writedata, exp_q[k].data);
         end
         if (!wb_stall) wbi++;
         tick();
      end
      wb_valid  = 1'b0;
      aux_valid = 1'b0;
      check("starve_once", stalls, 1);
      tick();
      tick();

      // Fill FIFO while writeback (to r0) holds the port
      for (int k = 0; k < 4; k++) begin
         wb_valid  = 1'b1;
         wb_addr   = 5'd0;
         wb_data   = 32'hDEAD;
         aux_valid = 1'b1;
         aux_addr  = ADDR_W'(20 + k);
         aux_data  = DATA_W'(32'h100 + k);
         @(negedge clk);
         check($sformatf("fill_rdy%0d", k), aux_ready, 1);
         check($sformatf("fill_r0_rw%0d", k), regwrite, 0);
         tick();
      end
      wb_valid  = 1'b0;
      aux_valid = 1'b1;
      aux_addr  = 5'd31;
      aux_data  = 32'hBAD;
      @(negedge clk);
      check("full_rdy", aux_ready, 0);
      check("full_stall", wb_stall, 1);
      check("full_r0_rw", regwrite, 0);
      tick();
      aux_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("drain_rw%0d", k), regwrite, 1);
         check($sformatf("drain_reg%0d", k), writereg, 20 + k);
         check($sformatf("drain_data%0d", k), writedata, 32'h100 + k);
         tick();
      end
      @(negedge clk);
      check("no_fifth_rw", regwrite, 0);
      check("no_fifth_reg", writereg, 23);
      check("drained_rdy", aux_ready, 1);
      tick();

      // Aux write to register zero
      chk_addr1 = 5'd0;
      chk_addr2 = 5'd0;
      aux_valid = 1'b1;
      aux_addr  = 5'd0;
      aux_data  = 32'h55;
      @(negedge clk);
      check("r0_hit1_a", chk_hit1, 0);
      tick();
      aux_valid = 1'b0;
      @(negedge clk);
      check("r0_hit1_b", chk_hit1, 0);
      check("r0_hit2_b", chk_hit2, 0);
      tick();
      @(negedge clk);
      check("r0_aux_rw", regwrite, 0);
      check("r0_hit1_c", chk_hit1, 0);
      tick();

      // Hazard check on a buffered write to r17
      chk_addr1 = 5'd17;
      chk_addr2 = 5'd16;
      aux_valid = 1'b1;
      aux_addr  = 5'd17;
      aux_data  = 32'h77;
      wb_valid  = 1'b1;
      wb_addr   = 5'd5;
      wb_data   = 32'd1;
      @(negedge clk);
      check("haz_hit1_q0", chk_hit1, 0);
      check("haz_hit2_q0", chk_hit2, 0);
      tick();
      aux_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wb_data = DATA_W'(k + 1);
         @(negedge clk);
         check($sformatf("haz_hit1_q%0d", k), chk_hit1, 1);
         check($sformatf("haz_hit2_q%0d", k), chk_hit2, 0);
         tick();
      end
      @(negedge clk);
      check("haz_out_rw", regwrite, 1);
      check("haz_out_reg", writereg, 17);
      check("haz_out_data", writedata, 32'h77);
      check("haz_out_hit1", chk_hit1, 1);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      check("haz_wb_reg", writereg, 5);
      check("haz_wb_data", writedata, 5);
      check("haz_clear_hit1", chk_hit1, 0);
      check("haz_clear_hit2", chk_hit2, 0);
      tick();
      tick();

      // Reset with three entries buffered
      chk_addr1 = 5'd21;
      chk_addr2 = 5'd0;
      for (int k = 0; k < 3; k++) begin
         wb_valid  = 1'b1;
         wb_addr   = 5'd0;
         aux_valid = 1'b1;
         aux_addr  = ADDR_W'(21 + k);
         aux_data  = DATA_W'(32'h200 + k);
         @(negedge clk);
         if (k == 2) check("mid_hit_buf", chk_hit1, 1);
         tick();
      end
      reset     = 1'b1;
      wb_valid  = 1'b0;
      aux_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_rdy", aux_ready, 1);
      check("mid_rst_stall", wb_stall, 0);
      check("mid_rst_hit", chk_hit1, 0);
      check("mid_rst_rw", regwrite, 0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_rw%0d", k), regwrite, 0);
         check($sformatf("post_rst_hit%0d", k), chk_hit1, 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
